// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: core-side sram-like and AXI master signals.
// master = bridge view, slave = core/memory environment view.
interface cpu_axi_bridge_if;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: inst/data sram-like ports onto one AXI master.
// AXI_BRIDGE_RESP_CHECK_EN adds a sticky bus_err output.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input logic clk,
  input logic reset,
  cpu_axi_bridge_if.master bus
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  ,
  output logic bus_err
`endif
);

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_R
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_SEND, W_B
  } w_state_t;

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [3:0]  r_id;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [1:0]  w_size;
  logic [3:0]  w_strb;
  logic        aw_pend;
  logic        w_pend;
  logic        raw_hit;
  logic        rd_data_acc;
  logic        rd_inst_acc;
  logic        wr_acc;
  logic        r_data_ok;
  logic        w_data_ok;

  assign raw_hit = (w_state != W_IDLE) &&
                   (bus.data_addr[31:2] == w_addr[31:2]);

  // Read FSM: grant, AR issue, R collect
  always_comb begin
    r_next           = r_state;
    rd_data_acc      = 1'b0;
    rd_inst_acc      = 1'b0;
    r_data_ok        = 1'b0;
    bus.arvalid      = 1'b0;
    bus.rready       = 1'b0;
    bus.inst_data_ok = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (bus.data_req && !bus.data_wr && !raw_hit) begin
          rd_data_acc = 1'b1;
          r_next      = R_AR;
        end else if (bus.inst_req) begin
          rd_inst_acc = 1'b1;
          r_next      = R_AR;
        end
      end
      R_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) r_next = R_R;
      end
      R_R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          if (bus.rid == ID_DATA) r_data_ok = 1'b1;
          else bus.inst_data_ok = 1'b1;
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_next;
      if (rd_data_acc) begin
        r_addr <= bus.data_addr;
        r_size <= bus.data_size;
        r_id   <= ID_DATA;
      end else if (rd_inst_acc) begin
        r_addr <= bus.inst_addr;
        r_size <= bus.inst_size;
        r_id   <= ID_INST;
      end
    end
  end

  // Write FSM: accept, AW/W in any order, B
  always_comb begin
    w_next      = w_state;
    wr_acc      = 1'b0;
    w_data_ok   = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (bus.data_req && bus.data_wr) begin
          wr_acc = 1'b1;
          w_next = W_SEND;
        end
      end
      W_SEND: begin
        bus.awvalid = aw_pend;
        bus.wvalid  = w_pend;
        if ((!aw_pend || bus.awready) &&
            (!w_pend || bus.wready))
          w_next = W_B;
      end
      W_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          w_data_ok = 1'b1;
          w_next    = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, payload and per-channel pend flags
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_data  <= '0;
      w_size  <= '0;
      w_strb  <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (wr_acc) begin
        w_addr  <= bus.data_addr;
        w_data  <= bus.data_wdata;
        w_size  <= bus.data_size;
        w_strb  <= bus.data_wstrb;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else if (w_state == W_SEND) begin
        if (bus.awready) aw_pend <= 1'b0;
        if (bus.wready) w_pend <= 1'b0;
      end
    end
  end

  assign bus.inst_addr_ok = rd_inst_acc;
  assign bus.data_addr_ok = rd_data_acc | wr_acc;
  assign bus.data_data_ok = r_data_ok | w_data_ok;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;
  assign bus.arid         = r_id;
  assign bus.araddr       = r_addr;
  assign bus.arsize       = {1'b0, r_size};
  assign bus.awaddr       = w_addr;
  assign bus.awsize       = {1'b0, w_size};
  assign bus.wdata        = w_data;
  assign bus.wstrb        = w_strb;

`ifdef AXI_BRIDGE_RESP_CHECK_EN
  // Sticky error on any non-OKAY R or B handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if ((bus.rvalid && bus.rready &&
                  bus.rresp != 2'b00) ||
                 (bus.bvalid && bus.bready &&
                  bus.bresp != 2'b00)) begin
      bus_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{bus.rresp, bus.bresp};
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: per-cycle vector table plus hand sequences
// for RAW blocking, reset in R_R and the optional bus_err.
module tb_cpu_axi_bridge;

  localparam logic [8:0] F_IAOK = 9'h100;
  localparam logic [8:0] F_IDOK = 9'h080;
  localparam logic [8:0] F_DAOK = 9'h040;
  localparam logic [8:0] F_DDOK = 9'h020;
  localparam logic [8:0] F_ARV  = 9'h010;
  localparam logic [8:0] F_RR   = 9'h008;
  localparam logic [8:0] F_AWV  = 9'h004;
  localparam logic [8:0] F_WV   = 9'h002;
  localparam logic [8:0] F_BR   = 9'h001;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [31:0] daddr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        arr;
    logic        rv;
    logic [3:0]  rid;
    logic [31:0] rd;
    logic        awr;
    logic        wr;
    logic        bv;
    logic [1:0]  br;
    logic [8:0]  flg;
    logic [3:0]  arid;
    logic [31:0] araddr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge_if bus ();

`ifdef AXI_BRIDGE_RESP_CHECK_EN
  logic bus_err;
  cpu_axi_bridge dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .bus_err(bus_err)
  );
`else
  cpu_axi_bridge dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
`endif

  function automatic vec_t cv(logic [8:0] f,
                              logic [3:0] id,
                              logic [31:0] a);
    vec_t v;
    v.rst = 0; v.ireq = 0; v.iaddr = 0;
    v.dreq = 0; v.dwr = 0; v.daddr = 0;
    v.strb = 0; v.wd = 0; v.arr = 0;
    v.rv = 0; v.rid = 0; v.rd = 0;
    v.awr = 0; v.wr = 0; v.bv = 0; v.br = 0;
    v.flg = f; v.arid = id; v.araddr = a;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    logic [8:0] act;
    @(negedge clk);
    reset          = v.rst;
    bus.inst_req   = v.ireq;
    bus.inst_addr  = v.iaddr;
    bus.inst_size  = 2'd2;
    bus.data_req   = v.dreq;
    bus.data_wr    = v.dwr;
    bus.data_addr  = v.daddr;
    bus.data_size  = 2'd2;
    bus.data_wstrb = v.strb;
    bus.data_wdata = v.wd;
    bus.arready    = v.arr;
    bus.rvalid     = v.rv;
    bus.rid        = v.rid;
    bus.rdata      = v.rd;
    bus.rresp      = 2'b00;
    bus.awready    = v.awr;
    bus.wready     = v.wr;
    bus.bvalid     = v.bv;
    bus.bresp      = v.br;
    #1;
    act = {bus.inst_addr_ok, bus.inst_data_ok,
           bus.data_addr_ok, bus.data_data_ok,
           bus.arvalid, bus.rready,
           bus.awvalid, bus.wvalid, bus.bready};
    nvec++;
    if (act !== v.flg) begin
      nbad++;
      $display("FAIL %s flags: got %b want %b",
               nm, act, v.flg);
    end else if (v.flg[4] &&
                 {bus.arid, bus.arsize, bus.araddr} !==
                 {v.arid, 3'd2, v.araddr}) begin
      nbad++;
      $display("FAIL %s ar: got %h/%h/%h want %h/2/%h",
               nm, bus.arid, bus.arsize, bus.araddr,
               v.arid, v.araddr);
    end else if (v.flg[7] && bus.inst_rdata !== v.rd) begin
      nbad++;
      $display("FAIL %s inst_rdata: got %h want %h",
               nm, bus.inst_rdata, v.rd);
    end else if (v.flg[5] && v.rv &&
                 bus.data_rdata !== v.rd) begin
      nbad++;
      $display("FAIL %s data_rdata: got %h want %h",
               nm, bus.data_rdata, v.rd);
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset = 1'b1;
    v = cv(9'h0, 4'd0, 32'h0);
    v.rst = 1'b1;
    bus.inst_req = 0; bus.inst_addr = 0; bus.inst_size = 2;
    bus.data_req = 0; bus.data_wr = 0; bus.data_addr = 0;
    bus.data_size = 2; bus.data_wstrb = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rid = 0;
    bus.rdata = 0; bus.rresp = 0; bus.awready = 0;
    bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    repeat (2) @(posedge clk);

    // reset state
    tbl.push_back(v);
    // instruction fetch, arready after 2 cycles
    v = cv(F_IAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000000; tbl.push_back(v);
    v = cv(F_ARV, 0, 32'h1c000000); tbl.push_back(v);
    v = cv(F_ARV, 0, 32'h1c000000); tbl.push_back(v);
    v = cv(F_ARV, 0, 32'h1c000000); v.arr = 1;
    tbl.push_back(v);
    v = cv(F_RR, 0, 0); tbl.push_back(v);
    v = cv(F_RR | F_IDOK, 0, 0); v.rv = 1;
    v.rid = 0; v.rd = 32'h02800000; tbl.push_back(v);
    v = cv(9'h0, 0, 0); tbl.push_back(v);
    // data read beats inst read
    v = cv(F_DAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000004; v.dreq = 1;
    v.daddr = 32'h1c008000; tbl.push_back(v);
    v = cv(F_ARV, 1, 32'h1c008000); v.ireq = 1;
    v.iaddr = 32'h1c000004; v.arr = 1; tbl.push_back(v);
    v = cv(F_RR | F_DDOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000004; v.rv = 1; v.rid = 1;
    v.rd = 32'hcafef00d; tbl.push_back(v);
    v = cv(F_IAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000004; tbl.push_back(v);
    v = cv(F_ARV, 0, 32'h1c000004); v.arr = 1;
    tbl.push_back(v);
    v = cv(F_RR | F_IDOK, 0, 0); v.rv = 1;
    v.rd = 32'h00000013; tbl.push_back(v);
    // store, awready 3 cycles before wready
    v = cv(F_DAOK, 0, 0); v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008004; v.strb = 4'b0011;
    v.wd = 32'h1234; tbl.push_back(v);
    v = cv(F_AWV | F_WV, 0, 0); v.awr = 1; tbl.push_back(v);
    v = cv(F_WV, 0, 0); tbl.push_back(v);
    v = cv(F_WV, 0, 0); tbl.push_back(v);
    v = cv(F_WV, 0, 0); v.wr = 1; tbl.push_back(v);
    v = cv(F_BR, 0, 0); tbl.push_back(v);
    v = cv(F_BR | F_DDOK, 0, 0); v.bv = 1; tbl.push_back(v);
    v = cv(9'h0, 0, 0); tbl.push_back(v);
    // inst read and data write accepted together
    v = cv(F_IAOK | F_DAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000008; v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008010; v.strb = 4'hf; v.wd = 5;
    tbl.push_back(v);
    v = cv(F_ARV | F_AWV | F_WV, 0, 32'h1c000008);
    v.arr = 1; v.awr = 1; v.wr = 1; tbl.push_back(v);
    v = cv(F_RR | F_IDOK | F_BR | F_DDOK, 0, 0);
    v.rv = 1; v.rd = 32'h11111111; v.bv = 1;
    tbl.push_back(v);
    v = cv(9'h0, 0, 0); tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // RAW: load to same word as pending store is held off
    v = cv(F_DAOK, 0, 0); v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008008; v.strb = 4'hf;
    v.wd = 32'ha5a5; apply(v, "raw_st");
    v = cv(F_AWV | F_WV, 0, 0); v.dreq = 1;
    v.daddr = 32'h1c00800a; apply(v, "raw_blk0");
    chk("awaddr", bus.awaddr, 32'h1c008008);
    chk("wdata", bus.wdata, 32'ha5a5);
    chk("wstrb_size", {bus.wstrb, bus.awsize}, {4'hf, 3'd2});
    v.awr = 1; v.wr = 1; apply(v, "raw_blk1");
    v = cv(F_BR, 0, 0); v.dreq = 1;
    v.daddr = 32'h1c00800a; apply(v, "raw_blk2");
    v = cv(F_BR | F_DDOK, 0, 0); v.dreq = 1;
    v.daddr = 32'h1c00800a; v.bv = 1; apply(v, "raw_blk3");
    v = cv(F_DAOK, 0, 0); v.dreq = 1;
    v.daddr = 32'h1c00800a; apply(v, "raw_acc");
    v = cv(F_ARV, 1, 32'h1c00800a); v.arr = 1;
    apply(v, "raw_ar");
    v = cv(F_RR | F_DDOK, 0, 0); v.rv = 1; v.rid = 1;
    v.rd = 32'h77; apply(v, "raw_r");
    // different word: load accepted at once
    v = cv(F_DAOK, 0, 0); v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008008; v.strb = 4'hf; v.wd = 9;
    apply(v, "nraw_st");
    v = cv(F_DAOK | F_AWV | F_WV, 0, 0); v.dreq = 1;
    v.daddr = 32'h1c00800c; apply(v, "nraw_ld");
    v = cv(F_ARV | F_AWV | F_WV, 1, 32'h1c00800c);
    v.arr = 1; v.awr = 1; v.wr = 1; apply(v, "nraw_ar");
    v = cv(F_RR | F_DDOK | F_BR, 0, 0); v.rv = 1;
    v.rid = 1; v.rd = 32'h88; apply(v, "nraw_r");
    v = cv(F_BR | F_DDOK, 0, 0); v.bv = 1;
    apply(v, "nraw_b");
    v = cv(9'h0, 0, 0); apply(v, "nraw_idle");

    // reset while in R_R abandons the read
    v = cv(F_IAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000010; apply(v, "rst_req");
    v = cv(F_ARV, 0, 32'h1c000010); v.arr = 1;
    apply(v, "rst_ar");
    v = cv(F_RR, 0, 0); v.rst = 1; apply(v, "rst_in_rr");
    v = cv(9'h0, 0, 0); v.rv = 1; v.rd = 32'hdead;
    apply(v, "rst_after");
    v = cv(F_IAOK, 0, 0); v.ireq = 1;
    v.iaddr = 32'h1c000014; apply(v, "rst_req2");
    v = cv(F_ARV, 0, 32'h1c000014); v.arr = 1;
    apply(v, "rst_ar2");
    v = cv(F_RR | F_IDOK, 0, 0); v.rv = 1;
    v.rd = 32'h01234567; apply(v, "rst_r2");

`ifdef AXI_BRIDGE_RESP_CHECK_EN
    chk("bus_err_init", {31'd0, bus_err}, 32'd0);
    v = cv(F_DAOK, 0, 0); v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008020; apply(v, "err_st");
    v = cv(F_AWV | F_WV, 0, 0); v.awr = 1; v.wr = 1;
    apply(v, "err_aw");
    v = cv(F_BR | F_DDOK, 0, 0); v.bv = 1; v.br = 2'b10;
    apply(v, "err_b");
    v = cv(9'h0, 0, 0); apply(v, "err_idle");
    chk("bus_err_set", {31'd0, bus_err}, 32'd1);
    v = cv(F_DAOK, 0, 0); v.dreq = 1; v.dwr = 1;
    v.daddr = 32'h1c008024; apply(v, "ok_st");
    v = cv(F_AWV | F_WV, 0, 0); v.awr = 1; v.wr = 1;
    apply(v, "ok_aw");
    v = cv(F_BR | F_DDOK, 0, 0); v.bv = 1;
    apply(v, "ok_b");
    v = cv(9'h0, 0, 0); apply(v, "ok_idle");
    chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);
    v = cv(9'h0, 0, 0); v.rst = 1; apply(v, "err_rst");
    v = cv(9'h0, 0, 0); apply(v, "err_rst_idle");
    chk("bus_err_clr", {31'd0, bus_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core. Consumes the core's instruction-side and data-side memory requests and produces a single AXI master port.
- Uses the team's sram-like handshake on the core side: req / addr_ok / data_ok.
- Keeps at most one outstanding read and one outstanding write at a time.
- Arbitrates the shared read channel between instruction fetch and data loads. Data loads win.

Parameters:
- ID_INST, 4'd0, arid used for instruction reads.
- ID_DATA, 4'd1, arid and awid used for data accesses.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  instruction read request.
- inst_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- inst_addr  in  32  instruction address.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction read data valid this cycle.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  access size.
- data_wstrb  in  4  byte enables.
- data_addr  in  32  data address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  load data valid, or store completed.
- data_rdata  out  32  load data.
- arid  out  4  AXI read address ID.
- araddr  out  32  AXI read address.
- arsize  out  3  AXI read size.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- rid  in  4  AXI read data ID.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- awaddr  out  32  AXI write address.
- awsize  out  3  AXI write size.
- awvalid  out  1  AXI write address valid.
- awready  in  1  AXI write address ready.
- wdata  out  32  AXI write data.
- wstrb  out  4  AXI write strobes.
- wvalid  out  1  AXI write data valid.
- wready  in  1  AXI write data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI write response valid.
- bready  out  1  AXI write response ready.
- Fixed AXI fields (len = 0, burst = INCR, lock/cache/prot = 0, wid = ID_DATA, wlast = 1) are tied off at the top level and are not ports of this block.

Behaviour:
- Reset: all valid, ready, addr_ok and data_ok outputs are 0; both state machines go to IDLE; address/data registers clear to 0. A reset during a transaction abandons it with no response to the core.
- Read FSM states: R_IDLE, R_AR, R_R.
  - R_IDLE: a data read (data_req & ~data_wr) has priority over inst_req.
  - On accept: the matching addr_ok is high combinationally in the same cycle; addr, size and id are latched; go to R_AR.
  - The losing requester sees addr_ok = 0 and must hold its request.
  - R_AR: arvalid = 1; araddr, arsize and arid come from registers; arsize = {1'b0, size}. Go to R_R on arready.
  - R_R: rready = 1. When rvalid is high, pulse the data_ok selected by rid for one cycle. rdata passes through combinationally to inst_rdata or data_rdata. Return to R_IDLE.
  - No new read is accepted in the cycle R_R completes; accepting resumes the next cycle.
- Write FSM states: W_IDLE, W_SEND, W_B.
  - W_IDLE: accept data_req & data_wr via data_addr_ok; latch addr, size, wstrb and wdata; set aw_pend = w_pend = 1.
  - W_SEND: awvalid = aw_pend and wvalid = w_pend. Each pend flag clears independently on its own ready. When both are clear, go to W_B.
  - W_B: bready = 1. On bvalid, pulse data_data_ok for one cycle and return to W_IDLE.
- data_addr_ok is driven by the read-FSM acceptance or the write-FSM acceptance, never both in one cycle.
- An instruction read and a data write may both be accepted in the same cycle.
- RAW hazard: while the write FSM is not idle, a data read with data_addr[31:2] equal to the pending awaddr[31:2] is not accepted. The instruction read may be granted in its place.
- Simultaneous read and write data_ok: both data_data_ok sources OR together; the core never has both outstanding on the data side.

Optional Feature:
- Macro: AXI_BRIDGE_RESP_CHECK_EN.
- Defined: adds output port bus_err (1 bit, reset 0). bus_err is sticky and is set when rresp != 0 at an rvalid & rready handshake, or bresp != 0 at a bvalid & bready handshake. Only reset clears it. Data is still returned.
- Undefined: the bus_err port is absent; rresp and bresp are ignored.

Test Plan:
- inst_req = 1, addr 0x1c000000; arready after 2 cycles; rvalid with rid = 0, rdata 0x02800000 -> inst_addr_ok in cycle 0, arid = 0, inst_data_ok pulses once, inst_rdata = 0x02800000.
- inst_req and a data read to 0x1c008000 in the same cycle -> data accepted first (arid = 1); inst_addr_ok stays 0 until the data read completes.
- Data store to 0x1c008004, wstrb 4'b0011, wdata 0x1234; awready 3 cycles before wready -> AW and W each handshake once; data_data_ok follows bvalid.
- Store to 0x1c008008 pending, then a load to 0x1c00800a -> load addr_ok held 0 until bvalid; a load to 0x1c00800c is accepted immediately.
- Reset asserted while in R_R -> next cycle arvalid = 0, rready = 0, no data_ok; a fresh inst_req is accepted normally.
- With AXI_BRIDGE_RESP_CHECK_EN defined: bresp = 2'b10 -> bus_err = 1 and stays 1 through later OKAY responses until reset.
